// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-storey elevator scheduler.
package elevator_pkg;

    localparam int NFLOOR       = 4;
    localparam int FLOOR_W      = 2;
    localparam int HOME_TIMEOUT = 40;

    typedef logic [FLOOR_W-1:0] floor_t;
    typedef logic [NFLOOR-1:0]  fmask_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_ARRIVE,
        ST_OPEN,
        ST_CLOSE
    } state_e;

    function automatic fmask_t floor_bit(input floor_t f);
        return fmask_t'(1) << f;
    endfunction

endpackage

// File: rtl/req_latch.sv
// Pending-request register bank for the elevator scheduler, plus the
// above/below/here summaries relative to the current floor.
module req_latch
    import elevator_pkg::*;
(
    input  logic   CP,
    input  logic   nCR,
    input  fmask_t set_i,
    input  logic   absorb_i,
    input  logic   enter_open_i,
    input  floor_t floor_i,
    output fmask_t pend_o,
    output logic   above_o,
    output logic   below_o,
    output logic   here_o
);

    fmask_t pend_q, pend_d;
    fmask_t here_m;

    assign here_m = floor_bit(floor_i);

    // While the door is open the current floor is absorbed (clear wins);
    // on the entry cycle a simultaneous new request still wins.
    always_comb begin
        pend_d = pend_q | set_i;
        if (absorb_i) begin
            pend_d = (pend_q | set_i) & ~here_m;
        end else if (enter_open_i) begin
            pend_d = (pend_q & ~here_m) | set_i;
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        above_o = 1'b0;
        below_o = 1'b0;
        for (int i = 0; i < NFLOOR; i++) begin
            if (i > int'(floor_i)) above_o = above_o | pend_q[i];
            if (i < int'(floor_i)) below_o = below_o | pend_q[i];
        end
    end

    assign here_o = |(pend_q & here_m);
    assign pend_o = pend_q;

endmodule

// File: rtl/elevator_sched_fsm.sv
// SCAN scheduling FSM for the 4-storey elevator; drives the run and open timers.
// Optional idle homing to floor 0 is enabled by defining HOME_RETURN_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | parked, door closed, waiting for a pending request
// ST_RUN    | moving one floor, mv2nxt held until the run timer completes
// ST_ARRIVE | one cycle at the new floor so the run timer can clear
// ST_OPEN   | door cycle, opendoor held until the open timer completes
// ST_CLOSE  | one cycle after the door cycle so the open timer can clear
module elevator_sched_fsm
    import elevator_pkg::*;
(
    input  logic              CP,
    input  logic              nCR,
    input  logic [NFLOOR-1:0] car_req,
    input  logic [NFLOOR-1:0] up_req,
    input  logic [NFLOOR-1:0] dn_req,
    input  logic              endRun,
    input  logic              endOpen,
    output logic              mv2nxt,
    output logic              opendoor,
    output logic [FLOOR_W-1:0] floor,
    output logic              dir_up,
    output logic              busy,
    output logic [NFLOOR-1:0] pend
);

    state_e state_q, state_d;
    floor_t floor_q, floor_d;
    logic   dir_q, dir_d;
    logic   end_run_q, end_open_q;
    logic   mv_q, open_q, busy_q;

    fmask_t raw_req, home_req, set_vec;
    logic   above, below, here;
    logic   run_ev, open_ev, ahead, behind;

    assign raw_req = car_req | (up_req & 4'b0111) | (dn_req & 4'b1110);
    assign set_vec = raw_req | home_req;
    assign run_ev  = endRun  & ~end_run_q;
    assign open_ev = endOpen & ~end_open_q;
    assign ahead   = dir_q ? above : below;
    assign behind  = dir_q ? below : above;

`ifdef HOME_RETURN_EN
    localparam int HCW = $clog2(HOME_TIMEOUT);

    logic [HCW-1:0] home_cnt_q, home_cnt_d;
    logic           home_arm;

    assign home_arm = (state_q == ST_IDLE) && (pend == '0) &&
                      (floor_q != '0) && (raw_req == '0);

    // Down-counter; terminal count injects a request for floor 0.
    always_comb begin
        home_cnt_d = HCW'(HOME_TIMEOUT - 1);
        home_req   = '0;
        if (home_arm) begin
            if (home_cnt_q == '0) begin
                home_req = fmask_t'(1);
            end else begin
                home_cnt_d = home_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            home_cnt_q <= HCW'(HOME_TIMEOUT - 1);
        end else begin
            home_cnt_q <= home_cnt_d;
        end
    end
`else
    assign home_req = '0;
`endif

    req_latch u_req_latch (
        .CP           (CP),
        .nCR          (nCR),
        .set_i        (set_vec),
        .absorb_i     (state_q == ST_OPEN),
        .enter_open_i ((state_d == ST_OPEN) && (state_q != ST_OPEN)),
        .floor_i      (floor_q),
        .pend_o       (pend),
        .above_o      (above),
        .below_o      (below),
        .here_o       (here)
    );

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (here) begin
                    state_d = ST_OPEN;
                end else if (above) begin
                    dir_d   = 1'b1;
                    state_d = ST_RUN;
                end else if (below) begin
                    dir_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_ev) begin
                    if (dir_q) begin
                        floor_d = (floor_q == floor_t'(NFLOOR - 1)) ? floor_q : floor_q + 1'b1;
                    end else begin
                        floor_d = (floor_q == '0) ? floor_q : floor_q - 1'b1;
                    end
                    state_d = ST_ARRIVE;
                end
            end
            ST_ARRIVE, ST_CLOSE: begin
                // here is always clear in CLOSE because OPEN absorbed it
                if (here) begin
                    state_d = ST_OPEN;
                end else if (ahead) begin
                    state_d = ST_RUN;
                end else if (behind) begin
                    dir_d   = ~dir_q;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (open_ev) state_d = ST_CLOSE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q    <= ST_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            end_run_q  <= 1'b0;
            end_open_q <= 1'b0;
            mv_q       <= 1'b0;
            open_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            end_run_q  <= endRun;
            end_open_q <= endOpen;
            mv_q       <= (state_d == ST_RUN);
            open_q     <= (state_d == ST_OPEN);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign mv2nxt   = mv_q;
    assign opendoor = open_q;
    assign busy     = busy_q;
    assign floor    = floor_q;
    assign dir_up   = dir_q;

endmodule

// File: tb/tb_elevator_sched_fsm.sv
// Self-checking bench for elevator_sched_fsm: directed scenarios plus a
// randomized run against a cycle-level behavioural model (HOME_RETURN_EN aware).
module tb_elevator_sched_fsm;

    logic       CP = 1'b0;
    logic       nCR;
    logic [3:0] car_req, up_req, dn_req;
    logic       endRun, endOpen;
    logic       mv2nxt, opendoor, dir_up, busy;
    logic [1:0] floor;
    logic [3:0] pend;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CP = ~CP;

    elevator_sched_fsm dut (
        .CP(CP), .nCR(nCR), .car_req(car_req), .up_req(up_req), .dn_req(dn_req),
        .endRun(endRun), .endOpen(endOpen), .mv2nxt(mv2nxt), .opendoor(opendoor),
        .floor(floor), .dir_up(dir_up), .busy(busy), .pend(pend)
    );

    // ---------------- behavioural reference model ----------------
    localparam int P_IDLE = 0, P_RUN = 1, P_ARRIVE = 2, P_OPEN = 3, P_CLOSE = 4;
    int m_ph, m_floor, m_pend;
    bit m_dir, m_prev_run, m_prev_open;
`ifdef HOME_RETURN_EN
    localparam int HOME_T = 40;
    int m_cnt;
`endif

    task automatic m_reset();
        m_ph = P_IDLE; m_floor = 0; m_pend = 0; m_dir = 1'b1;
        m_prev_run = 1'b0; m_prev_open = 1'b0;
`ifdef HOME_RETURN_EN
        m_cnt = 0;
`endif
    endtask

    // One clock edge of the model, using the inputs currently applied.
    task automatic m_step();
        int raw, setv, nph, nfl, here_bit;
        bit ndir, ev_r, ev_o, above, below, ahead, behind, here;
        raw  = int'(car_req) | (int'(up_req) & 7) | (int'(dn_req) & 14);
        setv = raw;
`ifdef HOME_RETURN_EN
        if (m_ph == P_IDLE && m_pend == 0 && m_floor != 0 && raw == 0) begin
            m_cnt++;
            if (m_cnt == HOME_T) begin setv = setv | 1; m_cnt = 0; end
        end else m_cnt = 0;
`endif
        ev_r = endRun && !m_prev_run;
        ev_o = endOpen && !m_prev_open;
        here_bit = 1 << m_floor;
        above = (m_pend >> (m_floor + 1)) != 0;
        below = (m_pend & (here_bit - 1)) != 0;
        here  = (m_pend & here_bit) != 0;
        ahead  = m_dir ? above : below;
        behind = m_dir ? below : above;
        nph = m_ph; nfl = m_floor; ndir = m_dir;
        case (m_ph)
            P_IDLE: begin
                if (here) nph = P_OPEN;
                else if (above) begin ndir = 1'b1; nph = P_RUN; end
                else if (below) begin ndir = 1'b0; nph = P_RUN; end
            end
            P_RUN: if (ev_r) begin
                nfl = m_dir ? ((m_floor < 3) ? m_floor + 1 : 3) : ((m_floor > 0) ? m_floor - 1 : 0);
                nph = P_ARRIVE;
            end
            P_OPEN: if (ev_o) nph = P_CLOSE;
            default: begin
                if (here && m_ph == P_ARRIVE) nph = P_OPEN;
                else if (ahead) nph = P_RUN;
                else if (behind) begin ndir = !m_dir; nph = P_RUN; end
                else nph = P_IDLE;
            end
        endcase
        if (m_ph == P_OPEN) m_pend = (m_pend | setv) & ~here_bit & 15;
        else if (nph == P_OPEN) m_pend = ((m_pend & ~here_bit) | setv) & 15;
        else m_pend = (m_pend | setv) & 15;
        m_ph = nph; m_floor = nfl; m_dir = ndir;
        m_prev_run = endRun; m_prev_open = endOpen;
    endtask

    // ---------------- helpers (no checking) ----------------
    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic do_reset();
        nCR = 1'b0; car_req = '0; up_req = '0; dn_req = '0; endRun = 1'b0; endOpen = 1'b0;
        step(); step();
        nCR = 1'b1;
        m_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_chk++; if (floor !== 2'd0)   begin n_fail++; $display("FAIL reset_floor got %0d want 0", floor); end
        n_chk++; if (dir_up !== 1'b1)  begin n_fail++; $display("FAIL reset_dir got %b want 1", dir_up); end
        n_chk++; if (mv2nxt !== 1'b0)  begin n_fail++; $display("FAIL reset_mv2nxt got %b want 0", mv2nxt); end
        n_chk++; if (opendoor !== 1'b0) begin n_fail++; $display("FAIL reset_opendoor got %b want 0", opendoor); end
        n_chk++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (pend !== 4'b0000) begin n_fail++; $display("FAIL reset_pend got %b want 0000", pend); end
    endtask

    task automatic test_travel_up();
        do_reset();
        car_req = 4'b1000; step(); car_req = '0;
        n_chk++; if (pend !== 4'b1000) begin n_fail++; $display("FAIL travel_latch got %b want 1000", pend); end
        step();
        n_chk++; if (mv2nxt !== 1'b1) begin n_fail++; $display("FAIL travel_start got %b want 1", mv2nxt); end
        for (int k = 1; k <= 3; k++) begin
            endRun = 1'b1; step(); endRun = 1'b0;
            n_chk++; if (floor !== 2'(k) || mv2nxt !== 1'b0) begin
                n_fail++; $display("FAIL travel_arrive%0d got floor=%0d mv=%b want floor=%0d mv=0", k, floor, mv2nxt, k);
            end
            step();
        end
        n_chk++; if (opendoor !== 1'b1 || pend !== 4'b0000 || mv2nxt !== 1'b0) begin
            n_fail++; $display("FAIL travel_open got od=%b pend=%b mv=%b want od=1 pend=0000 mv=0", opendoor, pend, mv2nxt);
        end
        endOpen = 1'b1; step(); endOpen = 1'b0; step();
        n_chk++; if (busy !== 1'b0 || floor !== 2'd3) begin
            n_fail++; $display("FAIL travel_idle got busy=%b floor=%0d want busy=0 floor=3", busy, floor);
        end
    endtask

    task automatic test_open_here();
        do_reset();
        up_req = 4'b0001; step(); up_req = '0;
        n_chk++; if (mv2nxt !== 1'b0 || opendoor !== 1'b0) begin
            n_fail++; $display("FAIL here_latch got mv=%b od=%b want 0 0", mv2nxt, opendoor);
        end
        step();
        n_chk++; if (opendoor !== 1'b1 || mv2nxt !== 1'b0) begin
            n_fail++; $display("FAIL here_open got od=%b mv=%b want od=1 mv=0", opendoor, mv2nxt);
        end
        endOpen = 1'b1; step(); endOpen = 1'b0; step();
        n_chk++; if (busy !== 1'b0 || pend !== 4'b0000) begin
            n_fail++; $display("FAIL here_done got busy=%b pend=%b want 0 0000", busy, pend);
        end
    endtask

    task automatic test_scan_order();
        int opens, rcnt, ocnt, cyc;
        int exp_fl[3], exp_pd[3];
        bit exp_dr[3], prev_od;
        int got_fl[3], got_pd[3];
        bit got_dr[3];
        exp_fl[0] = 2; exp_fl[1] = 3; exp_fl[2] = 0;
        exp_dr[0] = 1; exp_dr[1] = 1; exp_dr[2] = 0;
        exp_pd[0] = 9; exp_pd[1] = 1; exp_pd[2] = 0;
        do_reset();
        car_req = 4'b1000; step(); car_req = '0; step();
        endRun = 1'b1; step(); endRun = 1'b0; step();
        dn_req = 4'b0100; car_req = 4'b0001; step(); dn_req = '0; car_req = '0;
        opens = 0; rcnt = 0; ocnt = 0; cyc = 0; prev_od = 1'b0;
        while (!(opens == 3 && busy == 1'b0) && cyc < 300) begin
            rcnt = mv2nxt ? rcnt + 1 : 0;
            ocnt = opendoor ? ocnt + 1 : 0;
            endRun  = (rcnt == 2);
            endOpen = (ocnt == 2);
            step(); cyc++;
            if (opendoor && !prev_od && opens < 3) begin
                got_fl[opens] = int'(floor); got_dr[opens] = dir_up; got_pd[opens] = int'(pend);
                opens++;
            end
            prev_od = opendoor;
        end
        endRun = 1'b0; endOpen = 1'b0;
        n_chk++; if (opens != 3 || busy !== 1'b0) begin
            n_fail++; $display("FAIL scan_timeout got opens=%0d busy=%b want 3 0", opens, busy);
        end
        for (int i = 0; i < opens; i++) begin
            n_chk++; if (got_fl[i] != exp_fl[i] || got_dr[i] != exp_dr[i] || got_pd[i] != exp_pd[i]) begin
                n_fail++; $display("FAIL scan_stop%0d got floor=%0d dir=%b pend=%0d want floor=%0d dir=%b pend=%0d",
                    i, got_fl[i], got_dr[i], got_pd[i], exp_fl[i], exp_dr[i], exp_pd[i]);
            end
        end
    endtask

    task automatic test_held_endrun_and_reset();
        do_reset();
        car_req = 4'b1000; step(); car_req = '0; step();
        endRun = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) begin
                n_chk++; if (mv2nxt !== 1'b0 || floor !== 2'd1) begin
                    n_fail++; $display("FAIL held_gap got mv=%b floor=%0d want 0 1", mv2nxt, floor);
                end
            end
            if (c == 1) begin
                n_chk++; if (mv2nxt !== 1'b1) begin n_fail++; $display("FAIL held_rerun got mv=%b want 1", mv2nxt); end
            end
        end
        endRun = 1'b0;
        n_chk++; if (floor !== 2'd1) begin n_fail++; $display("FAIL held_once got floor=%0d want 1", floor); end
        step(); endRun = 1'b1; step(); endRun = 1'b0;
        n_chk++; if (floor !== 2'd2) begin n_fail++; $display("FAIL held_next got floor=%0d want 2", floor); end
        step();
        n_chk++; if (mv2nxt !== 1'b1) begin n_fail++; $display("FAIL midrun_setup got mv=%b want 1", mv2nxt); end
        #2 nCR = 1'b0;
        #1;
        n_chk++; if (floor !== 2'd0 || mv2nxt !== 1'b0 || busy !== 1'b0 || pend !== 4'b0000 || dir_up !== 1'b1) begin
            n_fail++; $display("FAIL midrun_async got floor=%0d mv=%b busy=%b pend=%b dir=%b want 0 0 0 0000 1",
                floor, mv2nxt, busy, pend, dir_up);
        end
        step(); nCR = 1'b1; step(); step(); step();
        n_chk++; if (mv2nxt !== 1'b0 || busy !== 1'b0 || pend !== 4'b0000) begin
            n_fail++; $display("FAIL midrun_noretain got mv=%b busy=%b pend=%b want 0 0 0000", mv2nxt, busy, pend);
        end
    endtask

    task automatic test_home();
        int rcnt, ocnt, cyc, rise;
        do_reset();
        car_req = 4'b0100; step(); car_req = '0;
        rcnt = 0; ocnt = 0; cyc = 0;
        while (!(busy == 1'b0 && floor == 2'd2) && cyc < 100) begin
            rcnt = mv2nxt ? rcnt + 1 : 0;
            ocnt = opendoor ? ocnt + 1 : 0;
            endRun = (rcnt == 2); endOpen = (ocnt == 2);
            step(); cyc++;
        end
        endRun = 1'b0; endOpen = 1'b0;
        n_chk++; if (busy !== 1'b0 || floor !== 2'd2) begin
            n_fail++; $display("FAIL home_park got busy=%b floor=%0d want 0 2", busy, floor);
        end
        rise = 0;
        for (int c = 1; c <= 100 && rise == 0; c++) begin
            step();
            if (mv2nxt) rise = c;
        end
`ifdef HOME_RETURN_EN
        n_chk++; if (rise != 41) begin n_fail++; $display("FAIL home_rise got cycle %0d want 41", rise); end
        rcnt = 0; ocnt = 0; cyc = 0;
        while (!opendoor && cyc < 100) begin
            rcnt = mv2nxt ? rcnt + 1 : 0;
            endRun = (rcnt == 2);
            step(); cyc++;
        end
        endRun = 1'b0;
        n_chk++; if (opendoor !== 1'b1 || floor !== 2'd0) begin
            n_fail++; $display("FAIL home_arrive got od=%b floor=%0d want 1 0", opendoor, floor);
        end
`else
        n_chk++; if (rise != 0 || floor !== 2'd2) begin
            n_fail++; $display("FAIL home_parked got rise=%0d floor=%0d want 0 2", rise, floor);
        end
`endif
    endtask

    task automatic test_random();
        logic [11:0] req;
        bit quiet;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            quiet = (cyc % 400) >= 300;
            req = '0;
            if (!quiet && $urandom_range(0, 5) == 0) req[$urandom_range(0, 11)] = 1'b1;
            car_req = req[3:0]; up_req = req[7:4]; dn_req = req[11:8];
            endRun  = ($urandom_range(0, 2) == 0);
            endOpen = ($urandom_range(0, 2) == 0);
            m_step();
            step();
            n_chk++;
            if (floor !== 2'(m_floor) || dir_up !== m_dir || mv2nxt !== (m_ph == P_RUN) ||
                opendoor !== (m_ph == P_OPEN) || busy !== (m_ph != P_IDLE) || pend !== 4'(m_pend)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rand_cyc%0d got fl=%0d dir=%b mv=%b od=%b busy=%b pend=%b want fl=%0d dir=%b mv=%b od=%b busy=%b pend=%b",
                    cyc, floor, dir_up, mv2nxt, opendoor, busy, pend, m_floor, m_dir,
                    m_ph == P_RUN, m_ph == P_OPEN, m_ph != P_IDLE, 4'(m_pend));
            end
            n_chk++;
            if ((mv2nxt && opendoor) || (mv2nxt && ((floor == 2'd3 && dir_up) || (floor == 2'd0 && !dir_up)))) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rand_invariant cyc%0d got mv=%b od=%b fl=%0d dir=%b", cyc, mv2nxt, opendoor, floor, dir_up);
            end
        end
        car_req = '0; up_req = '0; dn_req = '0; endRun = 1'b0; endOpen = 1'b0;
    endtask

    initial begin
        nCR = 1'b0; car_req = '0; up_req = '0; dn_req = '0; endRun = 1'b0; endOpen = 1'b0;
        test_reset();
        test_travel_up();
        test_open_here();
        test_scan_order();
        test_held_endrun_and_reset();
        test_home();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
